// File: rtl/dmem_responder.sv
// Data-memory target for the processor load/store path: one request at a time,
// WAIT wait states, byte/half/word little-endian lanes, misalign/range errors.
module dmem_responder #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic [1:0]  dbg_state_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    // Handshake: req is taken on any rising edge where busy=0; busy then stays
    // high until the single-cycle ack (with err) has been presented.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem [DEPTH];

    logic        accept, commit;
    logic        cur_we;
    logic [1:0]  cur_size, lane;
    logic [31:0] cur_addr, cur_wdata;
    logic [AW-1:0] idx;
    logic        acc_err;
    logic [3:0]  be;
    logic [31:0] wd_rep, rd_word, rd_shift, ld_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT);
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        ack         = (state_q == S_RESP);
        err         = (state_q == S_RESP) && err_q;
        rdata       = rdata_q;
        dbg_state_o = state_q;
    end

    // With WAIT=0 the access commits on the accept edge, so the live inputs
    // stand in for the not-yet-latched copy while idle.
    always_comb begin
        accept    = (state_q == S_IDLE) && req;
        commit    = rst && (state_d == S_RESP) && (state_q != S_RESP);
        cur_we    = (state_q == S_IDLE) ? we    : we_q;
        cur_size  = (state_q == S_IDLE) ? size  : size_q;
        cur_addr  = (state_q == S_IDLE) ? addr  : addr_q;
        cur_wdata = (state_q == S_IDLE) ? wdata : wdata_q;
        idx       = cur_addr[AW+1:2];
        lane      = cur_addr[1:0];
        acc_err   = (cur_size == 2'b11)
                  || ((cur_size == 2'b01) && lane[0])
                  || ((cur_size == 2'b10) && (lane != 2'b00))
                  || (|cur_addr[31:AW+2]);
        be        = 4'b1111;
        wd_rep    = cur_wdata;
        if (cur_size == 2'b00) begin
            be     = 4'b0001 << lane;
            wd_rep = {4{cur_wdata[7:0]}};
        end else if (cur_size == 2'b01) begin
            be     = lane[1] ? 4'b1100 : 4'b0011;
            wd_rep = {2{cur_wdata[15:0]}};
        end
        rd_word  = mem[idx];
        rd_shift = rd_word >> {lane, 3'b000};
        unique case (cur_size)
            2'b00:   ld_data = {24'd0, rd_shift[7:0]};
            2'b01:   ld_data = {16'd0, rd_shift[15:0]};
            default: ld_data = rd_word;
        endcase
        err_d   = commit ? acc_err : err_q;
        rdata_d = (commit && !cur_we && !acc_err) ? ld_data : rdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (accept) begin
                we_q    <= we;
                size_q  <= size;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    // Array survives reset; only committed, error-free stores touch it.
    always_ff @(posedge clk) begin
        if (commit && cur_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wd_rep[8*b +: 8];
            end
        end
    end

endmodule
